// File: rtl/traffic_controller_param_pkg.sv
// rtl/traffic_controller_param_pkg.sv - phase encoding, lamp constants and helpers for the traffic controller
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [2:0] lamp_slice(input phase_e ph, input logic is_active);
        logic [2:0] s;
        s = LAMP_RED;
        if (is_active && ph == GREEN)  s = LAMP_GRN;
        if (is_active && ph == YELLOW) s = LAMP_YEL;
        return s;
    endfunction

endpackage

// File: rtl/rr_demand_picker.sv
// rtl/rr_demand_picker.sv - chooses the next approach: valid emergency first, else round-robin demand scan
module rr_demand_picker #(
    parameter int N_APPR = 4,
    parameter int IW     = $clog2(N_APPR)
) (
    input  logic [N_APPR-1:0] req,
    input  logic [IW-1:0]     active_id,
    input  logic              emerg_valid,
    input  logic [IW-1:0]     emerg_id,
    output logic              emerg_ok,
    output logic [IW-1:0]     sel,
    output logic              other_req
);

    logic [IW-1:0] scan_sel;
    logic [IW-1:0] cand;

    always_comb begin
        emerg_ok  = emerg_valid && (32'(emerg_id) < N_APPR);
        other_req = |(req & ~(N_APPR'(1) << active_id));
        scan_sel  = IW'((int'(active_id) + 1) % N_APPR);
        cand      = '0;
        // Walk from farthest to nearest so the nearest requester wins; the current approach is k=N_APPR.
        for (int k = N_APPR; k >= 1; k--) begin
            cand = IW'((int'(active_id) + k) % N_APPR);
            if (req[cand]) scan_sel = cand;
        end
        sel = emerg_ok ? emerg_id : scan_sel;
    end

endmodule

// File: rtl/traffic_controller_param.sv
// rtl/traffic_controller_param.sv - N-approach traffic light controller with demand extension and emergency preemption
module traffic_controller_param
    import traffic_pkg::*;
#(
    parameter int N_APPR    = 4,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 16,
    parameter int YEL_T     = 3,
    parameter int AR_T      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_APPR-1:0]          req,
    input  logic                       emerg_valid,
    input  logic [$clog2(N_APPR)-1:0]  emerg_id,
    output logic [3*N_APPR-1:0]        lights,
    output logic [$clog2(N_APPR)-1:0]  active_id,
    output logic [1:0]                 phase
);

    localparam int IW = $clog2(N_APPR);
    // Timer is wide enough for the longest interval so yellow/all-red never hit saturation early.
    localparam int TW = $clog2(max3(GREEN_MAX, YEL_T, AR_T) + 1);

    phase_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       active_q, active_d;
    logic [3*N_APPR-1:0] lights_q, lights_d;

    logic          emerg_ok;
    logic [IW-1:0] sel;
    logic          other_req;
    int            t_next;

    rr_demand_picker #(
        .N_APPR (N_APPR),
        .IW     (IW)
    ) u_picker (
        .req         (req),
        .active_id   (active_q),
        .emerg_valid (emerg_valid),
        .emerg_id    (emerg_id),
        .emerg_ok    (emerg_ok),
        .sel         (sel),
        .other_req   (other_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ALL_RED;
            timer_q  <= '0;
            active_q <= IW'(N_APPR - 1);
            lights_q <= {N_APPR{LAMP_RED}};
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            lights_q <= lights_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        timer_d  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        t_next   = int'(timer_q) + 1;
        case (state_q)
            ALL_RED: begin
                if (t_next >= AR_T) begin
                    state_d  = GREEN;
                    active_d = sel;
                    timer_d  = '0;
                end
            end
            GREEN: begin
                if (emerg_ok) begin
                    if (emerg_id != active_q) begin
                        state_d = YELLOW;
                        timer_d = '0;
                    end
                end else if ((t_next >= GREEN_MIN && other_req) || t_next >= GREEN_MAX) begin
                    state_d = YELLOW;
                    timer_d = '0;
                end
            end
            YELLOW: begin
                if (t_next >= YEL_T) begin
                    state_d = ALL_RED;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ALL_RED;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        lights_d = '0;
        for (int i = 0; i < N_APPR; i++) begin
            lights_d[3*i +: 3] = lamp_slice(state_d, active_d == IW'(i));
        end
    end

    assign lights    = lights_q;
    assign active_id = active_q;
    assign phase     = state_q;

endmodule
